// File: rtl/edge_thresh_ctrl.sv
// edge_thresh_ctrl: per-frame mean-gradient threshold scheduler for edge binarisation.
// The threshold is swapped only after a full frame has been measured, divided and scaled.
module edge_thresh_ctrl #(
    parameter logic [11:0] H_DISP  = 12'd640,
    parameter logic [11:0] V_DISP  = 12'd480,
    parameter int          SUM_W   = 30,
    parameter logic [10:0] TH_INIT = 11'd100,
    parameter logic [10:0] TH_MIN  = 11'd16,
    parameter logic [10:0] TH_MAX  = 11'd1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        g_de,
    input  logic        g_vsync,
    input  logic [10:0] g_data,
    input  logic        cfg_auto,
    input  logic [10:0] cfg_thresh_manual,
    input  logic [3:0]  cfg_gain,
    output logic [10:0] thresh,
    output logic        thresh_valid,
    output logic        frame_err,
    output logic        busy
);
    localparam logic [19:0] FRAME_PX = 20'(H_DISP) * 20'(V_DISP);
    localparam int STEP_W = $clog2(SUM_W + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W - 1);

    typedef enum logic [1:0] {IDLE, DIV, SCALE, UPDATE} state_t;

    state_t            state_q, state_d;
    logic              vs_q;
    logic [SUM_W-1:0]  sum_q, sum_d, quo_q, quo_d, rem_q, rem_d;
    logic [19:0]       cnt_q, cnt_d, div_q, div_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              auto_q, auto_d;
    logic [10:0]       man_q, man_d, v_q, v_d, thresh_q, thresh_d;
    logic [3:0]        gain_q, gain_d;
    logic              valid_q, valid_d, err_q, err_d;
    logic              e0, ge;
    logic [SUM_W:0]    rem_sh, div_ext;
    logic [14:0]       prod;
    logic [12:0]       scaled;

    assign e0      = g_vsync & ~vs_q;
    assign rem_sh  = {rem_q, quo_q[SUM_W-1]};
    assign div_ext = {{(SUM_W-19){1'b0}}, div_q};
    assign ge      = rem_sh >= div_ext;
    assign prod    = {4'b0, quo_q[10:0]} * {11'b0, gain_q};
    assign scaled  = 13'(prod >> 2);

    always_comb begin
        state_d  = state_q;
        sum_d    = g_de ? sum_q + SUM_W'(g_data) : sum_q;
        cnt_d    = (g_de && cnt_q != '1) ? cnt_q + 20'd1 : cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        div_d    = div_q;
        step_d   = step_q;
        auto_d   = auto_q;
        man_d    = man_q;
        gain_d   = gain_q;
        v_d      = v_q;
        thresh_d = thresh_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            DIV: begin
                rem_d  = SUM_W'(ge ? rem_sh - div_ext : rem_sh);
                quo_d  = {quo_q[SUM_W-2:0], ge};
                step_d = step_q + 1'b1;
                if (step_q == LAST_STEP)
                    state_d = SCALE;
            end
            SCALE: begin
                v_d = !auto_q ? man_q :
                      scaled < {2'b0, TH_MIN} ? TH_MIN :
                      scaled > {2'b0, TH_MAX} ? TH_MAX : scaled[10:0];
                state_d = UPDATE;
            end
            UPDATE: begin
                state_d  = IDLE;
                thresh_d = (div_q == FRAME_PX) ? v_q : thresh_q;
                valid_d  = div_q == FRAME_PX;
                err_d    = div_q != FRAME_PX;
            end
            default: ;
        endcase
        // A frame edge always wins: any in-flight result is discarded and the new frame restarts.
        if (e0) begin
            thresh_d = thresh_q;
            valid_d  = 1'b0;
            err_d    = state_q != IDLE;
            sum_d    = g_de ? SUM_W'(g_data) : '0;
            cnt_d    = {19'd0, g_de};
            div_d    = cnt_q;
            quo_d    = sum_q;
            rem_d    = '0;
            step_d   = '0;
            auto_d   = cfg_auto;
            man_d    = cfg_thresh_manual;
            gain_d   = cfg_gain;
            state_d  = (cnt_q == '0) ? UPDATE : DIV;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vs_q     <= 1'b0;
            sum_q    <= '0;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            step_q   <= '0;
            auto_q   <= 1'b0;
            man_q    <= '0;
            gain_q   <= '0;
            v_q      <= '0;
            thresh_q <= TH_INIT;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            vs_q     <= g_vsync;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            step_q   <= step_d;
            auto_q   <= auto_d;
            man_q    <= man_d;
            gain_q   <= gain_d;
            v_q      <= v_d;
            thresh_q <= thresh_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign thresh       = thresh_q;
    assign thresh_valid = valid_q;
    assign frame_err    = err_q;
    assign busy         = state_q == DIV || state_q == SCALE;
endmodule

// File: tb/tb_edge_thresh_ctrl.sv
// tb_edge_thresh_ctrl: directed frames on a 4x2 display with hand-computed thresholds.
module tb_edge_thresh_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        g_de, g_vsync;
    logic [10:0] g_data;
    logic        cfg_auto;
    logic [10:0] cfg_thresh_manual;
    logic [3:0]  cfg_gain;
    logic [10:0] thresh;
    logic        thresh_valid, frame_err, busy;
    int nvec = 0;
    int nerr = 0;
    int vc, ec, nv, nb, th31;

    edge_thresh_ctrl #(.H_DISP(12'd4), .V_DISP(12'd2), .SUM_W(30)) dut (
        .clk(clk), .rst_n(rst_n), .g_de(g_de), .g_vsync(g_vsync), .g_data(g_data),
        .cfg_auto(cfg_auto), .cfg_thresh_manual(cfg_thresh_manual), .cfg_gain(cfg_gain),
        .thresh(thresh), .thresh_valid(thresh_valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives n pixels, one idle clock, then a vsync rise; returns just after the E0 edge.
    task automatic frame(input int n, input int g, input bit hold);
        for (int i = 0; i < n; i++) begin
            g_de = 1'b1;
            g_data = 11'(g);
            tick();
        end
        g_de = 1'b0;
        tick();
        g_vsync = 1'b1;
        tick();
        if (!hold)
            g_vsync = 1'b0;
    endtask

    // Observes 40 clocks after E0; k counts edges after E0, -1 means never seen.
    task automatic run(output int v_at, output int e_at, output int n_valid,
                       output int n_busy, output int th_at31);
        v_at = -1;
        e_at = -1;
        n_valid = 0;
        n_busy = 0;
        th_at31 = -1;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0)
                tick();
            if (thresh_valid) begin
                n_valid++;
                if (v_at < 0)
                    v_at = k;
            end
            if (frame_err && e_at < 0)
                e_at = k;
            if (busy)
                n_busy++;
            if (k == 31)
                th_at31 = int'(thresh);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        g_de = 1'b0;
        g_vsync = 1'b0;
        g_data = '0;
        cfg_auto = 1'b0;
        cfg_thresh_manual = 11'd300;
        cfg_gain = 4'd4;
        tick();
        tick();
        chk("rst_thresh", int'(thresh), 100);
        chk("rst_valid", int'(thresh_valid), 0);
        chk("rst_err", int'(frame_err), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        frame(8, 50, 1'b0);
        run(vc, ec, nv, nb, th31);
        chk("man_latency", vc, 32);
        chk("man_thresh", int'(thresh), 300);
        chk("man_pre_thresh", th31, 100);
        chk("man_nvalid", nv, 1);
        chk("man_err", ec, -1);
        chk("man_busy_cycles", nb, 31);

        cfg_auto = 1'b1;
        cfg_gain = 4'd4;
        frame(8, 200, 1'b0);
        cfg_gain = 4'd9;
        run(vc, ec, nv, nb, th31);
        chk("auto_g4_thresh", int'(thresh), 200);
        chk("auto_g4_latency", vc, 32);

        cfg_gain = 4'd2;
        frame(8, 200, 1'b1);
        run(vc, ec, nv, nb, th31);
        g_vsync = 1'b0;
        tick();
        chk("auto_g2_thresh", int'(thresh), 100);
        chk("vs_hold_err", ec, -1);
        chk("vs_hold_nvalid", nv, 1);

        cfg_gain = 4'd15;
        frame(8, 2047, 1'b0);
        run(vc, ec, nv, nb, th31);
        chk("clamp_max", int'(thresh), 1023);
        frame(8, 0, 1'b0);
        run(vc, ec, nv, nb, th31);
        chk("clamp_min", int'(thresh), 16);

        frame(7, 500, 1'b0);
        run(vc, ec, nv, nb, th31);
        chk("short_err_at", ec, 32);
        chk("short_nvalid", nv, 0);
        chk("short_thresh", int'(thresh), 16);
        frame(0, 0, 1'b0);
        run(vc, ec, nv, nb, th31);
        chk("empty_err_at", ec, 1);
        chk("empty_busy", nb, 0);
        chk("empty_thresh", int'(thresh), 16);

        cfg_gain = 4'd4;
        frame(8, 300, 1'b0);
        for (int i = 0; i < 8; i++) begin
            g_de = 1'b1;
            g_data = 11'd600;
            tick();
        end
        g_de = 1'b0;
        tick();
        g_vsync = 1'b1;
        tick();
        g_vsync = 1'b0;
        run(vc, ec, nv, nb, th31);
        chk("abort_err_at", ec, 0);
        chk("abort_latency", vc, 32);
        chk("abort_nvalid", nv, 1);
        chk("abort_thresh", int'(thresh), 600);

        frame(8, 800, 1'b0);
        for (int i = 0; i < 5; i++)
            tick();
        chk("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_thresh", int'(thresh), 100);
        chk("mid_rst_busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        tick();
        frame(8, 400, 1'b0);
        run(vc, ec, nv, nb, th31);
        chk("post_rst_thresh", int'(thresh), 400);
        chk("post_rst_latency", vc, 32);
        chk("post_rst_err", ec, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
